// File: rtl/pw_conv_accum_requant_if.sv
// Handshake/data bundle between the pointwise engine, its activation/weight/bias sources and the write port.
// No logic: the slave modport is the engine side, the master modport the source/sink side.
// Configuration macro PW_RELU_EN does not affect this file.
interface pw_conv_accum_requant_if #(
  parameter int PAR         = 4,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16
);
  localparam int LANE_W = (PAR > 1) ? $clog2(PAR) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [7:0]                   in_data;
  logic [PAR*8-1:0]             in_weight;
  logic [PAR*BIAS_WIDTH-1:0]    bias_in;
  logic [PAR*SCALE_WIDTH-1:0]   scale_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [7:0]                   out_data;
  logic [LANE_W-1:0]            out_lane;
  logic                         out_last;

  modport slave (
    input  in_valid, in_data, in_weight, bias_in, scale_in, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last
  );

  modport master (
    output in_valid, in_data, in_weight, bias_in, scale_in, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/pw_conv_accum_requant.sv
// 1x1 conv engine: PAR lanes accumulate IN_CH beats, then bias + Q8.8 scale + round + clamp, lanes streamed out.
// Latency: first result valid 2 cycles after the final input beat; PAR output beats follow (one per accepted cycle).
// Backpressure: out_ready low holds the current lane stable; inputs are refused (in_ready=0) outside accumulation.
// Macro PW_RELU_EN: defined -> ReLU clamp to 0..255 unsigned, undefined -> signed saturation to -128..127.
module pw_conv_accum_requant #(
  parameter int IN_CH       = 16,
  parameter int PAR         = 4,
  parameter int ACC_W       = 24,
  parameter int BIAS_WIDTH  = 32,
  parameter int SCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  output logic                      busy,
  pw_conv_accum_requant_if.slave    bus
);

  localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int LW = (PAR > 1) ? $clog2(PAR) : 1;
  // Sum of accumulator and bias needs one guard bit over the wider operand.
  localparam int SW = ((ACC_W > BIAS_WIDTH) ? ACC_W : BIAS_WIDTH) + 1;
  // Full product plus one bit so the rounding offset can never overflow.
  localparam int PW = SW + SCALE_WIDTH + 1;

  localparam logic [CW-1:0] LAST_CH   = CW'(IN_CH - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PAR - 1);

`ifdef PW_RELU_EN
  localparam logic signed [PW-1:0] CLAMP_LO = PW'(0);
  localparam logic signed [PW-1:0] CLAMP_HI = PW'(255);
`else
  localparam logic signed [PW-1:0] CLAMP_LO = PW'(-128);
  localparam logic signed [PW-1:0] CLAMP_HI = PW'(127);
`endif

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_MUL = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t                       state;
  logic [CW-1:0]                ch_cnt;
  logic [LW-1:0]                lane_cnt;
  logic signed [ACC_W-1:0]      acc      [PAR];
  logic [7:0]                   res      [PAR];
  logic [PAR*BIAS_WIDTH-1:0]    bias_q;
  logic [PAR*SCALE_WIDTH-1:0]   scale_q;
  logic                         rdy_q;
  logic                         vld_q;
  logic                         last_q;
  logic                         busy_q;

  logic signed [15:0]           prod     [PAR];
  logic signed [ACC_W-1:0]      prod_ext [PAR];
  logic signed [SW-1:0]         sum      [PAR];
  logic signed [PW-1:0]         scaled   [PAR];
  logic signed [PW-1:0]         rnd      [PAR];
  logic [7:0]                   res_next [PAR];

  // Per-lane 8x8 signed product, sign-extended to the accumulator width.
  always_comb begin
    for (int k = 0; k < PAR; k++) begin
      prod[k]     = $signed(bus.in_data) * $signed(bus.in_weight[8*k +: 8]);
      prod_ext[k] = ACC_W'(prod[k]);
    end
  end

  // Requantisation: bias add, Q8.8 scale, round-half-up via +128 then arithmetic shift, clamp.
  always_comb begin
    for (int k = 0; k < PAR; k++) begin
      sum[k]    = SW'(acc[k]) + SW'($signed(bias_q[BIAS_WIDTH*k +: BIAS_WIDTH]));
      scaled[k] = PW'(sum[k]) * PW'($signed(scale_q[SCALE_WIDTH*k +: SCALE_WIDTH]));
      rnd[k]    = (scaled[k] + PW'(128)) >>> 8;
      if (rnd[k] < CLAMP_LO) begin
        res_next[k] = CLAMP_LO[7:0];
      end else if (rnd[k] > CLAMP_HI) begin
        res_next[k] = CLAMP_HI[7:0];
      end else begin
        res_next[k] = rnd[k][7:0];
      end
    end
  end

  // Control FSM with registered handshake flags; flush aborts any pixel in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ACC;
      ch_cnt   <= '0;
      lane_cnt <= '0;
      bias_q   <= '0;
      scale_q  <= '0;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int k = 0; k < PAR; k++) begin
        acc[k] <= '0;
        res[k] <= '0;
      end
    end else if (flush) begin
      state    <= ST_ACC;
      ch_cnt   <= '0;
      lane_cnt <= '0;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int k = 0; k < PAR; k++) begin
        acc[k] <= '0;
      end
    end else begin
      case (state)
        ST_ACC: begin
          if (bus.in_valid) begin
            for (int k = 0; k < PAR; k++) begin
              acc[k] <= acc[k] + prod_ext[k];
            end
            busy_q <= 1'b1;
            if (ch_cnt == LAST_CH) begin
              ch_cnt  <= '0;
              bias_q  <= bus.bias_in;
              scale_q <= bus.scale_in;
              rdy_q   <= 1'b0;
              state   <= ST_MUL;
            end else begin
              ch_cnt <= ch_cnt + 1'b1;
            end
          end
        end
        ST_MUL: begin
          for (int k = 0; k < PAR; k++) begin
            res[k] <= res_next[k];
            acc[k] <= '0;
          end
          lane_cnt <= '0;
          vld_q    <= 1'b1;
          last_q   <= (PAR == 1);
          state    <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            if (lane_cnt == LAST_LANE) begin
              lane_cnt <= '0;
              vld_q    <= 1'b0;
              last_q   <= 1'b0;
              rdy_q    <= 1'b1;
              busy_q   <= 1'b0;
              state    <= ST_ACC;
            end else begin
              lane_cnt <= lane_cnt + 1'b1;
              last_q   <= ((lane_cnt + 1'b1) == LAST_LANE);
            end
          end
        end
        default: begin
          state  <= ST_ACC;
          rdy_q  <= 1'b1;
          vld_q  <= 1'b0;
          last_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Flush must suppress both handshakes within its own cycle, so it gates the registered flags.
  assign bus.in_ready  = rdy_q && !flush;
  assign bus.out_valid = vld_q && !flush;
  assign bus.out_data  = res[lane_cnt];
  assign bus.out_lane  = lane_cnt;
  assign bus.out_last  = last_q;
  assign busy          = busy_q;

endmodule

// File: doc/pw_conv_accum_requant.md
# pw_conv_accum_requant

Parametrised 1×1 (pointwise) convolution engine for the depthwise/pointwise layer pair. It computes PAR output channels in parallel for one pixel. It accepts IN_CH activation/weight beats, accumulates per lane, then applies bias, Q8.8 scale, rounding and clamping. The PAR results are streamed out one lane per beat over valid/ready. It sits between the feature-map read port (activations), weight memory (PAR-wide weight bus) and bias/scale memory, and feeds the feature-map write port.

## Interface
Parameters:
- IN_CH, 16, input channels accumulated per pixel (≥1)
- PAR, 4, output lanes computed in parallel (≥1)
- ACC_W, 24, accumulator width; must be ≥ 16+$clog2(IN_CH)
- BIAS_WIDTH, 32, bias width per lane
- SCALE_WIDTH, 16, scale width per lane, signed Q8.8

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous abort, active-high
- in_valid  input  1  activation/weight beat valid
- in_ready  output  1  engine accepts beat
- in_data  input  8  signed activation
- in_weight  input  PAR*8  signed weights; lane k at [8k+7:8k]
- bias_in  input  PAR*BIAS_WIDTH  signed per-lane bias; sampled on the final beat of a pixel
- scale_in  input  PAR*SCALE_WIDTH  signed per-lane Q8.8 scale; sampled on the final beat
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  8  requantised result
- out_lane  output  max(1,$clog2(PAR))  lane index of out_data
- out_last  output  1  high with lane PAR-1
- busy  output  1  high in any state other than ACC with ch_cnt==0

## Operation
- FSM states: ACC, MUL, OUT.
- ACC:
  - in_ready=1.
  - Each accepted beat does acc[k] += sext(in_data*in_weight[k]), with a 16-bit signed product and a two's-complement wrap at ACC_W.
  - ch_cnt counts 0..IN_CH-1.
  - On the beat with ch_cnt==IN_CH-1: latch bias_in and scale_in, clear ch_cnt, go to MUL.
- MUL, one cycle, in_ready=0, per lane:
  - s = sext(acc[k]) + sext(bias[k]), BIAS_WIDTH+1 bits.
  - p = s*scale[k], full width.
  - r = (p + 128) >>> 8, arithmetic shift.
  - Clamp r per the Configuration section and register the result into res[k].
  - Clear acc[k]. Go to OUT with lane_cnt=0.
- OUT:
  - out_valid=1, out_data=res[lane_cnt], out_lane=lane_cnt, out_last=(lane_cnt==PAR-1).
  - On out_valid&&out_ready: lane_cnt++.
  - After lane PAR-1 is accepted, go to ACC.
  - in_ready=0 throughout OUT; there is no overlap of the next pixel.
- flush:
  - Overrides everything in its cycle: acc=0, ch_cnt=0, lane_cnt=0, state=ACC, out_valid=0.
  - No beat is accepted in the flush cycle (in_ready forced 0).
- in_valid while in_ready=0 is ignored; the source must hold it.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=0, out_lane=0, out_last=0, busy=0.
  - State=ACC, all acc/res/ch_cnt/lane_cnt=0.
- Latency: if the final beat is accepted in cycle N, MUL is active in N+1 and out_valid rises in N+2.
- With out_ready held 1, lanes appear in cycles N+2..N+1+PAR, and in_ready returns in N+2+PAR.
- Throughput per pixel: IN_CH+1+PAR cycles minimum.
- Output handshake: while out_valid=1 and out_ready=0, out_data, out_lane and out_last hold stable.
- Reset asserted mid-pixel or mid-OUT returns all outputs to their reset values immediately; partial results are discarded.
- IN_CH=1: every accepted beat is the final beat.
- PAR=1: out_last=1 on every result.

## Configuration
- Macro PW_RELU_EN.
- Defined: ReLU fused. r<0 gives 0, r>255 gives 255, and out_data is unsigned 0..255.
- Undefined: signed saturation. r<-128 gives -128 (8'h80), r>127 gives 127, and out_data is two's complement.

## Test plan
- Reset/idle, PAR=4, IN_CH=16:
  - Stimulus: assert rst low mid-accumulation.
  - Required response: in_ready=1, out_valid=0, busy=0. The next pixel's results equal a fresh computation, unaffected by the discarded partial sums.
- Basic pixel:
  - Stimulus: in_data=2, all weights=3 for 16 beats, bias=0, scale=0x0100.
  - Required response: acc=96, and four results of 96 on lanes 0..3 with out_last on lane 3. The first out_valid appears exactly 2 cycles after the 16th beat.
- Rounding and scale:
  - Stimulus: acc=5 (one nonzero beat 5×1), bias=0, scale=0x0080.
  - Required response: out_data=3, since (640+128)>>>8=3.
  - Stimulus: acc=-5, same scale.
  - Required response: -2 (8'hFE) without PW_RELU_EN, 0 with it.
- Clamping:
  - Stimulus: bias=100000, scale=0x0100.
  - Required response: 255 with PW_RELU_EN, 127 without.
  - Stimulus: bias=-100000.
  - Required response: 0 with PW_RELU_EN, -128 without.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 during OUT.
  - Required response: out_data, out_lane and out_last hold during stalls; every lane is delivered exactly once and in order. in_ready stays 0 until lane 3 is accepted, then goes 1 in the next cycle.
- flush:
  - Stimulus: assert flush after 7 beats.
  - Required response: no output is produced. A following 16-beat pixel produces results identical to the Basic pixel case.
